// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave with frame-level command decode.
//
// Each frame is DATA_W+2 bits, MSB first: cmd[1:0] followed by the payload.
// cmd[1]=0 is a write frame. cmd[1]=1 is a read: the first read frame carries
// the address and arms rd_addr_flag; the next read frame is followed by
// DATA_W bits of tx_data on MISO, after which the flag is disarmed.
//
// Ports:
//   clk        SPI serial clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   SS_n       slave select, active low; high returns to IDLE from any state
//   MOSI       serial data in, MSB first
//   tx_valid   read data present on tx_data (only looked at in TX_WAIT)
//   tx_data    read data to shift out on MISO
//   MISO       registered serial data out, MSB first, 0 outside TX_SHIFT
//   rx_valid   one-cycle pulse, rx_data holds a complete frame
//   rx_data    last complete frame {cmd[1:0], payload}, held between frames
//   busy       high whenever the FSM is not in IDLE
//   frame_err  one-cycle pulse when a frame is aborted by SS_n mid-transfer
//              (only present when SPI_SLAVE_FRAME_ERR_EN is defined)
module spi_slave_param #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  // Counter value present while the last frame bit is being sampled.
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    TX_WAIT,
    TX_SHIFT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-2:0] rx_sh_q;
  logic [DATA_W-2:0]  tx_sh_q;
  logic [FRAME_W-1:0] rx_data_q;
  logic               rx_valid_q;
  logic               miso_q;
  logic               rd_addr_flag_q;
  logic               rx_last;
  logic               tx_last;

  assign rx_last = (cnt_q == RX_LAST);
  assign tx_last = (cnt_q == TX_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SS_n high overrides everything.
  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_flag_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE:     if (rx_last)  state_d = DONE;
        READ_ADD:  if (rx_last)  state_d = DONE;
        READ_DATA: if (rx_last)  state_d = TX_WAIT;
        TX_WAIT:   if (tx_valid) state_d = TX_SHIFT;
        TX_SHIFT:  if (tx_last)  state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Datapath. MISO defaults to 0 each cycle and is only set on edges whose
  // next state is TX_SHIFT, so it can never be high outside that state.
  // The first bit is driven straight from tx_data when leaving TX_WAIT; the
  // remaining DATA_W-1 bits come from tx_sh_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      rx_sh_q        <= '0;
      tx_sh_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_flag_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      if (SS_n) begin
        cnt_q <= '0;
      end else begin
        unique case (state_q)
          CHK_CMD: begin
            rx_sh_q <= {rx_sh_q[FRAME_W-3:0], MOSI};
            cnt_q   <= CNT_W'(1);
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_sh_q <= {rx_sh_q[FRAME_W-3:0], MOSI};
            if (rx_last) begin
              rx_data_q  <= {rx_sh_q, MOSI};
              rx_valid_q <= 1'b1;
              cnt_q      <= '0;
              if (state_q == READ_ADD) begin
                rd_addr_flag_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          TX_WAIT: begin
            if (tx_valid) begin
              miso_q  <= tx_data[DATA_W-1];
              tx_sh_q <= tx_data[DATA_W-2:0];
              cnt_q   <= '0;
            end
          end
          TX_SHIFT: begin
            if (tx_last) begin
              cnt_q          <= '0;
              rd_addr_flag_q <= 1'b0;
            end else begin
              miso_q  <= tx_sh_q[DATA_W-2];
              tx_sh_q <= {tx_sh_q[DATA_W-3:0], 1'b0};
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;

  // An abort is SS_n going high while a frame or read-out is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= SS_n && (state_q != IDLE) && (state_q != DONE);
    end
  end

  assign frame_err = frame_err_q;
`endif

  // Outputs
  always_comb begin
    busy     = (state_q != IDLE);
    MISO     = miso_q;
    rx_valid = rx_valid_q;
    rx_data  = rx_data_q;
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param (DATA_W=8 main instance, DATA_W=16
// secondary instance). The driver issues frames and pushes expected results
// (rx frames with their cycle, MISO bits per cycle, abort pulses); monitors
// on the falling edge compare the DUT outputs against those expectations.
module tb_spi_slave_param;
  localparam int unsigned DW   = 8;
  localparam int unsigned FW   = DW + 2;
  localparam int unsigned DW16 = 16;
  localparam int unsigned FW16 = DW16 + 2;

  typedef struct {
    logic [FW16-1:0] data;
    int unsigned     at;
  } rx_exp_t;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          SS_n     = 1'b1;
  logic          MOSI     = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data  = '0;
  logic          MISO, rx_valid, busy;
  logic [FW-1:0] rx_data;

  logic            ss16   = 1'b1;
  logic            mosi16 = 1'b0;
  logic            txv16  = 1'b0;
  logic [DW16-1:0] txd16  = '0;
  logic            miso16, rxv16, busy16;
  logic [FW16-1:0] rxd16;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err, ferr16;
  bit   exp_ferr[int unsigned];
`endif

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  rx_exp_t     rxq[$];
  rx_exp_t     q16[$];
  bit          exp_miso[int unsigned];
  logic [FW-1:0] rx_hold = '0;
  logic        busy_exp   = 1'b0;
  logic        busy16_exp = 1'b0;
  bit          flag_m     = 1'b0;

  spi_slave_param #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .MISO     (MISO),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  spi_slave_param #(.DATA_W(DW16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (ss16),
    .MOSI     (mosi16),
    .tx_valid (txv16),
    .tx_data  (txd16),
    .MISO     (miso16),
    .rx_valid (rxv16),
    .rx_data  (rxd16),
    .busy     (busy16)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(ferr16)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Busy after an edge is simply "slave select was sampled low there".
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_exp   <= 1'b0;
      busy16_exp <= 1'b0;
    end else begin
      busy_exp   <= !SS_n;
      busy16_exp <= !ss16;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin : mon8
      rx_exp_t x;
      check("busy", {63'd0, busy}, {63'd0, busy_exp});
      check("MISO", {63'd0, MISO}, exp_miso.exists(cyc) ? 64'(exp_miso[cyc]) : 64'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("frame_err", {63'd0, frame_err}, exp_ferr.exists(cyc) ? 64'd1 : 64'd0);
`endif
      if (rx_valid) begin
        if (rxq.size() == 0) begin
          check("rx_valid_unexpected", {63'd0, rx_valid}, 64'd0);
        end else begin
          x = rxq.pop_front();
          check("rx_data", 64'(rx_data), 64'(x.data));
          check("rx_valid_cycle", 64'(cyc), 64'(x.at));
          rx_hold = x.data[FW-1:0];
        end
      end else begin
        check("rx_data_hold", 64'(rx_data), 64'(rx_hold));
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin : mon16
      rx_exp_t x;
      check("miso16", {63'd0, miso16}, 64'd0);
      check("busy16", {63'd0, busy16}, {63'd0, busy16_exp});
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("frame_err16", {63'd0, ferr16}, 64'd0);
`endif
      if (rxv16) begin
        if (q16.size() == 0) begin
          check("rx16_unexpected", {63'd0, rxv16}, 64'd0);
        end else begin
          x = q16.pop_front();
          check("rx16_data", 64'(rxd16), 64'(x.data));
          check("rx16_cycle", 64'(cyc), 64'(x.at));
        end
      end
    end
  end

  // Drive one bit period; e is the rising edge that will sample these inputs.
  task automatic step(input logic ss, input logic mosi, input logic tv,
                      input logic [DW-1:0] td, output int unsigned e);
    @(negedge clk);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = tv;
    tx_data  = td;
    e        = cyc + 1;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    #1;
    check("rst_MISO", {63'd0, MISO}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("rst_rx_data", 64'(rx_data), 64'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    exp_ferr.delete();
`endif
    exp_miso.delete();
    rxq.delete();
    rx_hold = '0;
    flag_m  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction. abort_at: frame bit (1..FW) replaced by SS_n high, 0 = none.
  // abort_tx: read-out period index (wait cycles, then the load, then shift
  // cycles) replaced by SS_n high, -1 = none. rst_k: reset while MISO shows
  // read-out bit rst_k, -1 = none.
  task automatic run_frame(input logic [FW-1:0] frame, input int abort_at,
                           input int unsigned wait_tx, input int abort_tx,
                           input int rst_k, input logic [DW-1:0] tx_byte);
    int unsigned e, et;
    rx_exp_t     x;
    step(1'b1, rb(), rb(), DW'($urandom), e);
    step(1'b0, rb(), rb(), DW'($urandom), e);
    for (int i = 1; i <= int'(FW); i++) begin
      if (i == abort_at) begin
        step(1'b1, rb(), rb(), DW'($urandom), e);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        exp_ferr[e] = 1'b1;
`endif
        return;
      end
      step(1'b0, frame[FW-i], rb(), DW'($urandom), e);
    end
    x.data = FW16'(frame);
    x.at   = e;
    rxq.push_back(x);
    if (frame[FW-1] && flag_m) begin
      for (int unsigned w = 0; w < wait_tx; w++) begin
        if (int'(w) == abort_tx) begin
          step(1'b1, rb(), 1'b0, DW'($urandom), e);
`ifdef SPI_SLAVE_FRAME_ERR_EN
          exp_ferr[e] = 1'b1;
`endif
          return;
        end
        step(1'b0, rb(), 1'b0, DW'($urandom), e);
      end
      step(1'b0, rb(), 1'b1, tx_byte, e);
      et = e;
      for (int unsigned k = 0; k < DW; k++) exp_miso[et + k] = tx_byte[DW-1-k];
      for (int unsigned k = 0; k < DW; k++) begin
        if (int'(k) == rst_k) begin
          mid_reset();
          return;
        end
        if (int'(wait_tx + 1 + k) == abort_tx) begin
          step(1'b1, rb(), rb(), DW'($urandom), e);
          for (int unsigned j = e; j < et + DW; j++) exp_miso.delete(j);
`ifdef SPI_SLAVE_FRAME_ERR_EN
          exp_ferr[e] = 1'b1;
`endif
          return;
        end
        step(1'b0, rb(), rb(), DW'($urandom), e);
      end
      flag_m = 1'b0;
    end else if (frame[FW-1]) begin
      flag_m = 1'b1;
    end
    repeat ($urandom_range(0, 3)) step(1'b0, rb(), rb(), DW'($urandom), e);
  endtask

  task automatic run16(input logic [FW16-1:0] frame);
    rx_exp_t x;
    @(negedge clk);
    ss16 = 1'b1;
    @(negedge clk);
    ss16   = 1'b0;
    mosi16 = rb();
    for (int unsigned i = 1; i <= FW16; i++) begin
      @(negedge clk);
      mosi16 = frame[FW16-i];
    end
    x.data = frame;
    x.at   = cyc + 1;
    q16.push_back(x);
    repeat (3) begin
      @(negedge clk);
      mosi16 = rb();
    end
    @(negedge clk);
    ss16 = 1'b1;
  endtask

  initial begin : main
    int unsigned e;
    #1;
    check("reset_MISO", {63'd0, MISO}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("reset_rx_data", 64'(rx_data), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame(10'h0A5, 0, 0, -1, -1, '0);     // write
    run_frame(10'h203, 0, 0, -1, -1, '0);     // read address, arms flag
    run_frame(10'h300, 0, 2, -1, -1, 8'hC3);  // read data, shifts C3
    run_frame(10'h3F0, 0, 0, -1, -1, '0);     // flag clear again: address path
    run_frame(10'h055, 6, 0, -1, -1, '0);     // abort after 5 bits
    run_frame(10'h3AA, 0, 1, -1, 3, 8'hFF);   // reset during read-out bit 3
    run_frame(10'h311, 0, 0, -1, -1, 8'hA5);  // address path after reset
    run_frame(10'h322, 0, 0, 4, -1, 8'h5A);   // abort mid read-out, flag kept
    run_frame(10'h333, 0, 0, -1, -1, 8'h96);  // read data using kept flag

    repeat (60) begin
      logic [FW-1:0] f;
      int            ab, at;
      f  = FW'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FW)) : 0;
      at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3 + DW)) : -1;
      run_frame(f, ab, $urandom_range(0, 3), at, -1, DW'($urandom));
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, e);
    check("rx_missing", 64'(rxq.size()), 64'd0);

    run16(18'h0ABCD);
    run16({2'b00, 16'($urandom)});
    run16({2'b01, 16'($urandom)});
    repeat (3) @(negedge clk);
    check("rx16_missing", 64'(q16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame, legal range 4..32; frame length is FRAME_W = DATA_W+2 (2 command bits + payload).
REQ-002 clk  input  1  SPI serial clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 SS_n  input  1  slave select, active low.
REQ-005 MOSI  input  1  serial data in, MSB first.
REQ-006 tx_valid  input  1  read data available on tx_data.
REQ-007 tx_data  input  DATA_W  read data to shift out.
REQ-008 MISO  output  1  serial data out, registered, MSB first.
REQ-009 rx_valid  output  1  one-cycle pulse, rx_data holds a complete frame.
REQ-010 rx_data  output  FRAME_W  received frame {cmd[1:0], payload}.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 frame_err  output  1  present only with SPI_SLAVE_FRAME_ERR_EN; one-cycle abort pulse.

Function
REQ-013 States SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
REQ-014 IDLE: SS_n sampled low -> CHK_CMD.
REQ-015 CHK_CMD: MOSI sampled is cmd[1], shifted in, bit count = 1; cmd[1]=0 -> WRITE; cmd[1]=1 and rd_addr_flag=0 -> READ_ADD; cmd[1]=1 and rd_addr_flag=1 -> READ_DATA.
REQ-016 WRITE/READ_ADD/READ_DATA shift MOSI into the receive register once per clock; counter width = clog2(FRAME_W+1).
REQ-017 On the clock sampling bit FRAME_W, rx_data SHALL load the full frame and rx_valid SHALL be high in the following cycle only.
REQ-018 Frame end: WRITE -> DONE; READ_ADD -> DONE and rd_addr_flag set; READ_DATA -> TX_WAIT.
REQ-019 TX_WAIT: hold until tx_valid sampled high, then latch tx_data into the transmit register -> TX_SHIFT.
REQ-020 TX_SHIFT: MISO SHALL drive tx_data[DATA_W-1-k] in the k-th cycle after entry (k = 0..DATA_W-1), then -> DONE and rd_addr_flag cleared.
REQ-021 MISO SHALL be 0 outside TX_SHIFT.
REQ-022 DONE: MOSI ignored, no rx_valid, remain until SS_n high.
REQ-023 SS_n sampled high in any state -> IDLE next cycle; counters cleared; a partial frame never produces rx_valid; rd_addr_flag retained.
REQ-024 tx_valid outside TX_WAIT SHALL be ignored.
REQ-025 rx_data SHALL hold its value between frames.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, rx_data 0, rx_valid 0, MISO 0, busy 0, frame_err 0, counters 0, rd_addr_flag 0, including mid-frame or mid-TX_SHIFT.

Configuration
REQ-027 Macro SPI_SLAVE_FRAME_ERR_EN defined: frame_err port exists and pulses high for one cycle when SS_n is sampled high in CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT or TX_SHIFT; no pulse in IDLE or DONE.
REQ-028 Macro undefined: frame_err port and its logic absent; all other behaviour identical.

Verification (DATA_W=8 unless stated)
REQ-029 Write frame: SS_n low, MOSI 00_1010_0101 -> single rx_valid pulse, rx_data=10'h0A5, state DONE, MISO 0 throughout.
REQ-030 Read-address then read-data: frame 10_0000_0011 -> rx_data=10'h203, flag set; after SS_n high/low, frame 11_0000_0000 -> rx_data=10'h300; tx_valid=1, tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1, then flag clear.
REQ-031 cmd 11 with flag clear: frame 11_1111_0000 -> READ_ADD path, rx_data=10'h3F0, flag set, no MISO activity.
REQ-032 Abort: SS_n high after 5 bits of a write -> no rx_valid, IDLE next cycle; with SPI_SLAVE_FRAME_ERR_EN, frame_err one-cycle pulse.
REQ-033 Reset asserted during TX_SHIFT bit 3 -> MISO 0, busy 0, flag 0 immediately; next read frame takes READ_ADD path.
REQ-034 DATA_W=16: 18-bit write frame 00_ABCD -> rx_data=18'h0ABCD, rx_valid once after bit 18.
